// File: rtl/timer_pkg.sv
// timer_pkg: register offsets and CTRL/STATUS field positions shared by the timer bank.
package timer_pkg;
    localparam logic [1:0] REG_COUNT  = 2'd0;
    localparam logic [1:0] REG_TARGET = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;
    localparam int PRESC_LO  = 8;
    localparam int PRESC_HI  = 15;
    localparam int ST_HIT    = 0;
    localparam int ST_OVF    = 1;
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one COUNT/TARGET/CTRL/STATUS set with optional prescaler (TIMER_PRESCALE_EN).
//   clk, rst (async active-low), we (already qualified for this channel), sel (register),
//   wdata (write data), rdata (selected register), hit (STATUS.HIT), irq (HIT & IE).
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEFAULT_TICKS = 500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             hit,
    output logic             irq
);
    logic [WIDTH-1:0] count_q, count_d, target_q, target_d;
    logic en_q, en_d, auto_q, auto_d, ie_q, ie_d, hit_q, hit_d, ovf_q, ovf_d;
    logic count_wr, target_wr, ctrl_wr, status_wr, tick, match, hit_set, ovf_set;
    logic [15:0] ctrl_rd;
`ifdef TIMER_PRESCALE_EN
    logic [7:0] presc_q, presc_d, pcnt_q, pcnt_d;
    logic [15:0] wx;
    assign wx = 16'(wdata);
`endif
    always_comb begin
        count_wr  = we && sel == REG_COUNT;
        target_wr = we && sel == REG_TARGET;
        ctrl_wr   = we && sel == REG_CTRL;
        status_wr = we && sel == REG_STATUS;
        match     = count_q == target_q;
`ifdef TIMER_PRESCALE_EN
        tick      = en_q && pcnt_q == presc_q;
        presc_d   = ctrl_wr ? wx[PRESC_HI:PRESC_LO] : presc_q;
        // counter idles at 0 while disabled, so enabling always starts a fresh prescale period
        pcnt_d    = (ctrl_wr || !en_q || tick) ? 8'd0 : pcnt_q + 8'd1;
        ctrl_rd   = {presc_q, 5'd0, ie_q, auto_q, en_q};
`else
        tick      = en_q;
        ctrl_rd   = {13'd0, ie_q, auto_q, en_q};
`endif
        // a COUNT write suppresses both the increment and the compare of that edge
        hit_set   = tick && !count_wr && match;
        ovf_set   = tick && !count_wr && !match && &count_q;
        count_d   = count_wr ? wdata : !tick ? count_q : match ? (auto_q ? '0 : count_q) : count_q + WIDTH'(1);
        target_d  = target_wr ? wdata : target_q;
        en_d      = ctrl_wr ? wdata[CTRL_EN] : (hit_set && !auto_q) ? 1'b0 : en_q;
        auto_d    = ctrl_wr ? wdata[CTRL_AUTO] : auto_q;
        ie_d      = ctrl_wr ? wdata[CTRL_IE] : ie_q;
        hit_d     = hit_set | (hit_q & ~(status_wr & wdata[ST_HIT]));
        ovf_d     = ovf_set | (ovf_q & ~(status_wr & wdata[ST_OVF]));
        rdata     = sel == REG_COUNT ? count_q : sel == REG_TARGET ? target_q :
                    sel == REG_CTRL ? WIDTH'(ctrl_rd) : WIDTH'({ovf_q, hit_q});
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            target_q <= WIDTH'(DEFAULT_TICKS);
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            ie_q     <= 1'b0;
            hit_q    <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            presc_q  <= '0;
            pcnt_q   <= '0;
`endif
        end else begin
            count_q  <= count_d;
            target_q <= target_d;
            en_q     <= en_d;
            auto_q   <= auto_d;
            ie_q     <= ie_d;
            hit_q    <= hit_d;
            ovf_q    <= ovf_d;
`ifdef TIMER_PRESCALE_EN
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
`endif
        end
    end
    assign hit = hit_q;
    assign irq = hit_q & ie_q;
endmodule

// File: rtl/timer_bank.sv
// timer_bank: CHANNELS independent programmable timers on a register bus, combined irq.
//   clk, rst (async active-low), we, addr {channel, reg}, dataIn, rdata (combinational),
//   flag (HIT per channel), irq (OR of HIT & IE). Prescaler built when TIMER_PRESCALE_EN is defined.
module timer_bank
    import timer_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int WIDTH         = 32,
    parameter int DEFAULT_TICKS = 500,
    localparam int AW           = $clog2(CHANNELS) + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [WIDTH-1:0]    dataIn,
    output logic [WIDTH-1:0]    rdata,
    output logic [CHANNELS-1:0] flag,
    output logic                irq
);
    logic [AW-1:0] ch;
    logic [WIDTH-1:0] rd_ch [CHANNELS];
    logic [CHANNELS-1:0] ch_irq;
    // shift keeps the decode valid for CHANNELS=1, where the channel field has no bits
    assign ch = addr >> 2;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        timer_channel #(.WIDTH(WIDTH), .DEFAULT_TICKS(DEFAULT_TICKS)) u_ch (
            .clk(clk), .rst(rst), .we(we && ch == AW'(i)), .sel(addr[1:0]), .wdata(dataIn),
            .rdata(rd_ch[i]), .hit(flag[i]), .irq(ch_irq[i])
        );
    end
    // unmatched (nonexistent) channel indices fall through to 0
    always_comb begin
        rdata = '0;
        for (int k = 0; k < CHANNELS; k++) rdata = ch == AW'(k) ? rd_ch[k] : rdata;
    end
    assign irq = |ch_irq;
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed vector table plus hand sequences for reset, overflow and collisions.
module tb_timer_bank;
    logic clk = 0, rst = 0, we = 0, we8 = 0;
    logic [3:0] addr = 0, addr8 = 0;
    logic [31:0] din = 0, rdata;
    logic [7:0] din8 = 0, rdata8;
    logic [3:0] flag;
    logic [2:0] flag8;
    logic irq, irq8;
    int total = 0, bad = 0;

    timer_bank #(.CHANNELS(4), .WIDTH(32), .DEFAULT_TICKS(500)) dut (
        .clk(clk), .rst(rst), .we(we), .addr(addr), .dataIn(din), .rdata(rdata), .flag(flag), .irq(irq));
    timer_bank #(.CHANNELS(3), .WIDTH(8), .DEFAULT_TICKS(100)) dut8 (
        .clk(clk), .rst(rst), .we(we8), .addr(addr8), .dataIn(din8), .rdata(rdata8), .flag(flag8), .irq(irq8));

    always #5 clk = ~clk;

    typedef struct {
        logic we; logic [3:0] wa; logic [31:0] wd;
        logic [3:0] ra; logic [31:0] er; logic [3:0] ef; logic ei;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(bit w, int wa, int wd, int ra, int er, int ef, bit ei);
        vec_t v;
        v.we = w; v.wa = 4'(wa); v.wd = 32'(wd); v.ra = 4'(ra); v.er = 32'(er); v.ef = 4'(ef); v.ei = ei;
        return v;
    endfunction

    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(int a, int d);
        we = 1; addr = 4'(a); din = 32'(d);
        @(negedge clk);
        we = 0;
    endtask

    task automatic wr8(int a, int d);
        we8 = 1; addr8 = 4'(a); din8 = 8'(d);
        @(negedge clk);
        we8 = 0;
    endtask

    task automatic chk_rd(string n, int a, int e);
        addr = 4'(a);
        #1;
        chk(n, rdata, 32'(e));
    endtask

    task automatic chk_rd8(string n, int a, int e);
        addr8 = 4'(a);
        #1;
        chk(n, 32'(rdata8), 32'(e));
    endtask

    initial begin
        // auto-reload on ch0 (TARGET=3, CTRL=EN|AUTO|IE)
        tv.push_back(mk(1, 1, 3, 1, 3, 0, 0));
        tv.push_back(mk(1, 2, 7, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 2, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 3, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 1));
        tv.push_back(mk(0, 0, 0, 3, 1, 1, 1));
        tv.push_back(mk(1, 3, 1, 3, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 3, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 1));
        tv.push_back(mk(1, 2, 3, 2, 3, 1, 0));
        tv.push_back(mk(1, 2, 0, 0, 2, 1, 0));
        tv.push_back(mk(1, 3, 3, 3, 0, 0, 0));
        // one-shot on ch1 (TARGET=5, CTRL=EN)
        tv.push_back(mk(1, 5, 5, 5, 5, 0, 0));
        tv.push_back(mk(1, 6, 1, 4, 0, 0, 0));
        for (int i = 1; i <= 5; i++) tv.push_back(mk(0, 0, 0, 4, i, 0, 0));
        tv.push_back(mk(0, 0, 0, 4, 5, 2, 0));
        tv.push_back(mk(0, 0, 0, 6, 0, 2, 0));
        tv.push_back(mk(0, 0, 0, 7, 1, 2, 0));
        tv.push_back(mk(1, 7, 1, 7, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 4, 5, 0, 0));

        step(2);
        chk_rd("rst_count", 0, 0);
        chk_rd("rst_target", 1, 500);
        chk_rd8("rst8_target", 1, 100);
        chk("rst_flag", 32'(flag), 0);
        chk("rst_irq", 32'(irq), 0);
        rst = 1;
        step(1);

        foreach (tv[i]) begin
            we = tv[i].we; addr = tv[i].wa; din = tv[i].wd;
            @(negedge clk);
            we = 0; addr = tv[i].ra;
            #1;
            chk($sformatf("vec%0d_rdata", i), rdata, tv[i].er);
            chk($sformatf("vec%0d_flag", i), 32'(flag), 32'(tv[i].ef));
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(tv[i].ei));
        end

        // COUNT write on the edge where old COUNT==TARGET
        wr(9, 2); wr(10, 3); step(2);
        chk_rd("col_pre", 8, 2);
        wr(8, 'h20);
        chk_rd("col_count", 8, 'h20);
        chk_rd("col_status", 11, 0);
        chk("col_flag", 32'(flag[2]), 0);
        wr(10, 0);
        chk_rd("col_next", 8, 'h21);

        // W1C STATUS on the HIT edge: set wins
        wr(13, 1); wr(14, 1); step(1);
        wr(15, 1);
        chk_rd("w1c_hit_edge", 15, 1);
        chk("w1c_flag", 32'(flag[3]), 1);
        wr(15, 1);
        chk_rd("w1c_clear", 15, 0);

        // overflow on the 8-bit bank
        wr8(1, 'h10); wr8(0, 'hFE); wr8(2, 1);
        chk_rd8("ovf_start", 0, 'hFE);
        step(1);
        chk_rd8("ovf_ff", 0, 'hFF);
        chk_rd8("ovf_st0", 3, 0);
        step(1);
        chk_rd8("ovf_wrap", 0, 0);
        chk_rd8("ovf_st1", 3, 2);
        step(16);
        chk_rd8("ovf_at_tgt", 0, 'h10);
        chk_rd8("ovf_st2", 3, 2);
        step(1);
        chk_rd8("ovf_hit_st", 3, 3);
        chk_rd8("ovf_hold", 0, 'h10);
        chk("ovf_flag8", 32'(flag8), 1);
        wr8(12, 'hAA); wr8(13, 'h55);
        chk_rd8("oob_rd12", 12, 0);
        chk_rd8("oob_rd13", 13, 0);

        // prescaler (or its absence) on ch0
        wr(0, 0); wr(1, 1); wr(2, 'h0301);
`ifdef TIMER_PRESCALE_EN
        chk_rd("ps_ctrl", 2, 'h0301);
        step(3);
        chk_rd("ps_c3", 0, 0);
        step(1);
        chk_rd("ps_c4", 0, 1);
        step(3);
        chk_rd("ps_st7", 3, 0);
        step(1);
        chk_rd("ps_st8", 3, 1);
`else
        chk_rd("ps_ctrl", 2, 'h0001);
        step(1);
        chk_rd("ps_c1", 0, 1);
        chk_rd("ps_st1", 3, 0);
        step(1);
        chk_rd("ps_st2", 3, 1);
`endif
        wr(3, 3);

        // asynchronous reset mid-count, checked before any clock edge
        wr(1, 1); wr(2, 7); step(2);
        chk("pre_rst_irq", 32'(irq), 1);
        rst = 0;
        chk_rd("arst_count", 0, 0);
        chk_rd("arst_target", 1, 500);
        chk_rd("arst_target3", 13, 500);
        chk("arst_flag", 32'(flag), 0);
        chk("arst_irq", 32'(irq), 0);
        step(1);
        rst = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
